wave_step_scheduler: RTL and testbench
======================================

# wave_step_scheduler

Sequences the 1-D wave simulation: streams cell state out of a ping-pong u/du memory through one shared, combinational `wave_unit`, writes results to the opposite bank, and swaps banks once per time step. After every `STEPS_PER_FRAME` steps it stalls stepping and hands the freshly written bank to `transmit_array` with a start/ready handshake. It sits in `top` between the state memories, the wave datapath and the UART path, replacing the fixed per-cell `wave_unit` array.

## Interface
- `N_CELLS`, 100, number of simulated cells (≥3)
- `ADDR_W`, 7, cell address width (2^ADDR_W ≥ N_CELLS)
- `STEPS_PER_FRAME`, 16, time steps between transmissions (≥1)

- `clk` in 1: system clock, 27 MHz
- `rst` in 1: synchronous, active-high reset
- `run` in 1: level; while high, steps are launched back to back
- `mem_raddr` out ADDR_W: read address into bank `bank_sel`
- `mem_u_rdata`, `mem_du_rdata` in 32 each: read data, valid exactly 1 cycle after address
- `wu_u`, `wu_du`, `wu_uL`, `wu_uR` out 32 each: operands to shared `wave_unit`
- `wu_u_new`, `wu_du_new` in 32 each: `wave_unit` results, same cycle
- `mem_we` out 1: write strobe into bank `~bank_sel`
- `mem_waddr` out ADDR_W: write address
- `mem_u_wdata`, `mem_du_wdata` out 32 each: equal to `wu_u_new` / `wu_du_new`
- `bank_sel` out 1: current (read/transmit) bank
- `tx_start` out 1: request to `transmit_array`
- `tx_ready` in 1: `transmit_array` ready
- `busy` out 1: high in any state other than IDLE
- `step_count` out 16: completed steps, wraps modulo 2^16

## Operation
- States: IDLE, STREAM, SWAP, TX_REQ, TX_WAIT.
- IDLE: if `run`=1, go to STREAM (stream cycle s=0); else stay.
- STREAM, s = 0..N_CELLS+1 (N_CELLS+2 cycles):
  - s ≤ N_CELLS-1: `mem_raddr`=s.
  - Window registers capture `mem_u_rdata` / `mem_du_rdata` each cycle: prev ← cur, cur ← rdata.
  - s ≥ 2: cell i=s-2 is computed. `wu_u`=u[i], `wu_du`=du[i], `wu_uL`=u[i-1] (0 for i=0), `wu_uR`=`mem_u_rdata`=u[i+1] (0 for i=N_CELLS-1).
  - On compute cycles, `mem_we`=1 and `mem_waddr`=i.
  - s=N_CELLS+1 → SWAP.
- SWAP (1 cycle): toggle `bank_sel`, increment `step_count` and internal frame counter.
  - If the frame counter reaches STEPS_PER_FRAME: clear it, go to TX_REQ.
  - Else go to STREAM if `run`=1, otherwise IDLE.
- TX_REQ: `tx_start`=1 until a cycle with `tx_ready`=1. That is the accept cycle; go to TX_WAIT.
- TX_WAIT: wait for `tx_ready`=0, then for `tx_ready`=1, then go to IDLE. Bank `bank_sel` must not be written in TX_REQ or TX_WAIT, so the transmitter reads a coherent frame.
- Arithmetic: the block performs none on cell data; values pass unmodified, 32-bit, unsigned bit patterns.
- `run` dropping mid-step: the current step, SWAP and any due transmit complete; the next step is not launched.
- `rst` mid-operation: state returns to IDLE next cycle and all outputs take reset values. Memory contents are untouched and any partially written bank is abandoned.

## Timing
- Reset values:
  - `mem_we`=0, `tx_start`=0, `busy`=0, `bank_sel`=0, `step_count`=0
  - `mem_raddr`=0, `mem_waddr`=0
  - all `wu_*` operands=0, frame counter=0
- One step costs N_CELLS+3 cycles (STREAM + SWAP); 103 cycles at default.
- First write occurs 2 cycles after STREAM entry; last write at STREAM cycle N_CELLS+1.
- Exactly N_CELLS writes per step, to addresses 0..N_CELLS-1 in order, each written once.
- `bank_sel` toggles on the clock edge ending SWAP.
- `tx_start` is never asserted before that edge.
- `tx_start` high for ≥1 cycle and deasserted the cycle after accept.
- `tx_ready` already low on entry to TX_WAIT is legal.
- If `run`=1 on return to IDLE, STREAM starts on the next cycle.

## Test plan
- Reset: assert `rst` 2 cycles with `run`=1 → all outputs at reset values; with `run`=1, `busy`=1 and `mem_raddr`=0 on the cycle after `rst` falls.
- Single step, N_CELLS=8, STEPS_PER_FRAME=4, bank0 u={0,0,0,1000,1000,0,0,0}, du=0 → writes to addresses 0..7 at STREAM cycles 2..9 with wave_unit golden values; `wu_uL`=0 at cell 0, `wu_uR`=0 at cell 7; `bank_sel`=1 and `step_count`=1 after 11 cycles.
- Frame handoff, STEPS_PER_FRAME=2, `tx_ready` held 0 for 50 cycles after step 2 → `tx_start` held, no `mem_we`; raise `tx_ready` → `tx_start` drops the next cycle; 0→1 ready pulse → stepping resumes.
- `run` dropped at STREAM cycle 3 → step completes (8 writes), SWAP occurs, then IDLE with `busy`=0 and no further reads.
- `rst` asserted at STREAM cycle 5 → `mem_we`=0 and `bank_sel`=0 next cycle; restart writes begin again at address 0.
- Default N_CELLS=100, u=200000000 at cells 46..54, run 64 steps with real `wave_unit` and `transmit_array` → both banks bit-exact with golden model; 4 transmissions of 400 bytes each.

Source files
------------

// File: rtl/wave_step_scheduler.sv
// Purpose: streams u/du cells from one ping-pong bank through a shared wave_unit into the other bank, then swaps banks.
// Latency: one step is N_CELLS+3 cycles (N_CELLS+2 stream + 1 swap); first write lands 2 cycles after stream entry.
// Backpressure: every STEPS_PER_FRAME steps, stepping halts until the transmitter accepts and then finishes a frame.
module wave_step_scheduler #(
  parameter int N_CELLS         = 100,
  parameter int ADDR_W          = 7,
  parameter int STEPS_PER_FRAME = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_u_rdata,
  input  logic [31:0]       mem_du_rdata,
  output logic [31:0]       wu_u,
  output logic [31:0]       wu_du,
  output logic [31:0]       wu_uL,
  output logic [31:0]       wu_uR,
  input  logic [31:0]       wu_u_new,
  input  logic [31:0]       wu_du_new,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_u_wdata,
  output logic [31:0]       mem_du_wdata,
  output logic              bank_sel,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       step_count
);

  // Stream counter must reach N_CELLS+1, one beyond the address range.
  localparam int SW = ADDR_W + 1;
  localparam int FW = $clog2(STEPS_PER_FRAME + 1);
  localparam logic [SW-1:0] S_NCELLS = SW'(N_CELLS);
  localparam logic [SW-1:0] S_FIRST  = SW'(2);
  localparam logic [SW-1:0] S_LAST   = SW'(N_CELLS + 1);
  localparam logic [FW-1:0] F_LAST   = FW'(STEPS_PER_FRAME - 1);

  typedef enum logic [2:0] {IDLE, STREAM, SWAP, TX_REQ, TX_WAIT} state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic [31:0]   prev_u;
  logic [31:0]   cur_u;
  logic [31:0]   cur_du;
  logic [FW-1:0] frame_cnt;
  logic          tx_seen_low;

  assign busy         = (state != IDLE);
  assign mem_u_wdata  = wu_u_new;
  assign mem_du_wdata = wu_du_new;

  // Address, operand and write-strobe decode from the stream position; idle values are all zero.
  always_comb begin
    mem_raddr = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    wu_u      = '0;
    wu_du     = '0;
    wu_uL     = '0;
    wu_uR     = '0;
    if (state == STREAM) begin
      if (s < S_NCELLS) begin
        mem_raddr = ADDR_W'(s);
      end
      if (s >= S_FIRST) begin
        // cur holds cell s-2, prev its left neighbour, rdata its right neighbour.
        mem_we    = 1'b1;
        mem_waddr = ADDR_W'(s - S_FIRST);
        wu_u      = cur_u;
        wu_du     = cur_du;
        wu_uL     = (s == S_FIRST) ? 32'd0 : prev_u;
        wu_uR     = (s == S_LAST)  ? 32'd0 : mem_u_rdata;
      end
    end
  end

  // Sequencer: stream, swap banks, and hand every completed frame to the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s           <= '0;
      prev_u      <= '0;
      cur_u       <= '0;
      cur_du      <= '0;
      frame_cnt   <= '0;
      bank_sel    <= 1'b0;
      step_count  <= '0;
      tx_start    <= 1'b0;
      tx_seen_low <= 1'b0;
    end else begin
      prev_u <= cur_u;
      cur_u  <= mem_u_rdata;
      cur_du <= mem_du_rdata;
      case (state)
        IDLE: begin
          if (run) begin
            s     <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (s == S_LAST) begin
            state <= SWAP;
          end else begin
            s <= s + 1'b1;
          end
        end
        SWAP: begin
          bank_sel   <= ~bank_sel;
          step_count <= step_count + 16'd1;
          s          <= '0;
          if (frame_cnt == F_LAST) begin
            frame_cnt <= '0;
            tx_start  <= 1'b1;
            state     <= TX_REQ;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= run ? STREAM : IDLE;
          end
        end
        TX_REQ: begin
          if (tx_ready) begin
            tx_start    <= 1'b0;
            tx_seen_low <= 1'b0;
            state       <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // Ready dropping marks the transfer as in progress; its return marks completion.
          if (!tx_seen_low) begin
            if (!tx_ready) begin
              tx_seen_low <= 1'b1;
            end
          end else if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_step_scheduler.sv
// Bench for wave_step_scheduler with a small array: random cell data, a ping-pong memory,
// an asymmetric stand-in wave_unit, and a step-level reference model of the banks.
module tb_wave_step_scheduler;

  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int SPF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          tx_ready;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_u_rdata, mem_du_rdata;
  logic [31:0]   wu_u, wu_du, wu_uL, wu_uR, wu_u_new, wu_du_new;
  logic [31:0]   mem_u_wdata, mem_du_wdata;
  logic          mem_we, bank_sel, tx_start, busy;
  logic [15:0]   step_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_u  [2][N];
  logic [31:0] mem_du [2][N];
  logic [31:0] init_u [2][N];
  logic [31:0] init_du[2][N];
  logic        load;

  logic [31:0] mu  [2][N];
  logic [31:0] mdu [2][N];
  int mb, fc, sc;

  wave_step_scheduler #(.N_CELLS(N), .ADDR_W(AW), .STEPS_PER_FRAME(SPF)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_raddr(mem_raddr), .mem_u_rdata(mem_u_rdata), .mem_du_rdata(mem_du_rdata),
    .wu_u(wu_u), .wu_du(wu_du), .wu_uL(wu_uL), .wu_uR(wu_uR),
    .wu_u_new(wu_u_new), .wu_du_new(wu_du_new),
    .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_u_wdata(mem_u_wdata), .mem_du_wdata(mem_du_wdata),
    .bank_sel(bank_sel), .tx_start(tx_start), .tx_ready(tx_ready),
    .busy(busy), .step_count(step_count)
  );

  // Stand-in wave_unit: left and right neighbours weighted differently so a swap is visible.
  function automatic logic [31:0] f_u(input logic [31:0] u, input logic [31:0] du);
    return u + du;
  endfunction

  function automatic logic [31:0] f_du(input logic [31:0] u, input logic [31:0] du,
                                       input logic [31:0] ul, input logic [31:0] ur);
    return du + ul + 32'd3 * ur - 32'd2 * u;
  endfunction

  assign wu_u_new  = f_u(wu_u, wu_du);
  assign wu_du_new = f_du(wu_u, wu_du, wu_uL, wu_uR);

  always #5 clk = ~clk;

  // Ping-pong memory: one-cycle read latency from bank_sel, writes into the other bank.
  always @(posedge clk) begin
    if (load) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem_u[b][i]  <= init_u[b][i];
          mem_du[b][i] <= init_du[b][i];
        end
      end
    end else begin
      mem_u_rdata  <= mem_u[bank_sel][mem_raddr];
      mem_du_rdata <= mem_du[bank_sel][mem_raddr];
      if (mem_we) begin
        mem_u[!bank_sel][mem_waddr]  <= mem_u_wdata;
        mem_du[!bank_sel][mem_waddr] <= mem_du_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [31:0] left_u(input int b, input int i);
    return (i == 0) ? 32'd0 : mu[b][i-1];
  endfunction

  function automatic logic [31:0] right_u(input int b, input int i);
    return (i == N - 1) ? 32'd0 : mu[b][i+1];
  endfunction

  // One wave step of the reference: cells 0..ncells-1 of bank mb land in the other bank.
  task automatic model_step(input int ncells);
    for (int i = 0; i < ncells; i++) begin
      mu[1-mb][i]  = f_u(mu[mb][i], mdu[mb][i]);
      mdu[1-mb][i] = f_du(mu[mb][i], mdu[mb][i], left_u(mb, i), right_u(mb, i));
    end
  endtask

  task automatic check_banks(input string tag);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        chk({tag, "_u"}, mem_u[b][i], mu[b][i]);
        chk({tag, "_du"}, mem_du[b][i], mdu[b][i]);
      end
    end
  endtask

  // Entered at the negedge of stream cycle 0; leaves at the negedge after the swap edge
  // (or right after a mid-step reset when abort_at matches a stream cycle).
  task automatic run_step(input int drop_at, input int abort_at);
    for (int c = 0; c <= N + 1; c++) begin
      chk("busy_stream", 32'(busy), 32'd1);
      chk("we_stream", 32'(mem_we), 32'(c >= 2));
      chk("tx_start_stream", 32'(tx_start), 32'd0);
      if (c < N) chk("raddr", 32'(mem_raddr), 32'(c));
      if (c >= 2) begin
        chk("waddr", 32'(mem_waddr), 32'(c - 2));
        chk("wu_u", wu_u, mu[mb][c-2]);
        chk("wu_du", wu_du, mdu[mb][c-2]);
        chk("wu_uL", wu_uL, left_u(mb, c - 2));
        chk("wu_uR", wu_uR, right_u(mb, c - 2));
        chk("wdata_u", mem_u_wdata, f_u(mu[mb][c-2], mdu[mb][c-2]));
      end
      if (c == drop_at) run = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        model_step(c - 1);
        tick;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step_count", 32'(step_count), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        check_banks("bank_after_abort");
        mb = 0; fc = 0; sc = 0;
        rst = 1'b0;
        return;
      end
      tick;
    end
    chk("we_swap", 32'(mem_we), 32'd0);
    chk("busy_swap", 32'(busy), 32'd1);
    chk("bank_before_toggle", 32'(bank_sel), 32'(mb));
    chk("tx_start_swap", 32'(tx_start), 32'd0);
    tick;
    model_step(N);
    mb = 1 - mb;
    sc++;
    fc++;
    chk("bank_sel_toggle", 32'(bank_sel), 32'(mb));
    chk("step_count", 32'(step_count), 32'(sc));
    check_banks("bank");
    if (fc == SPF) begin
      fc = 0;
    end else begin
      chk("busy_after_swap", 32'(busy), 32'(run));
      chk("tx_start_no_frame", 32'(tx_start), 32'd0);
    end
  endtask

  // Entered at the negedge right after a frame-ending swap; leaves at the negedge in IDLE.
  task automatic do_tx(input int hold_cycles, input int low_cycles);
    chk("tx_start_req", 32'(tx_start), 32'd1);
    chk("busy_req", 32'(busy), 32'd1);
    chk("we_req", 32'(mem_we), 32'd0);
    for (int k = 0; k < hold_cycles; k++) begin
      tick;
      chk("tx_start_held", 32'(tx_start), 32'd1);
      chk("we_held", 32'(mem_we), 32'd0);
    end
    tx_ready = 1'b1;
    tick;
    chk("tx_start_drop", 32'(tx_start), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    tx_ready = 1'b0;
    for (int k = 0; k < low_cycles; k++) begin
      tick;
      chk("busy_wait_low", 32'(busy), 32'd1);
      chk("we_wait_low", 32'(mem_we), 32'd0);
    end
    tx_ready = 1'b1;
    tick;
    chk("busy_idle_after_tx", 32'(busy), 32'd0);
    chk("bank_stable_tx", 32'(bank_sel), 32'(mb));
    check_banks("bank_tx");
    tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    tx_ready = 1'b0;
    load = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        init_u[b][i]  = $urandom;
        init_du[b][i] = $urandom;
        mu[b][i]      = init_u[b][i];
        mdu[b][i]     = init_du[b][i];
      end
    end
    mb = 0; fc = 0; sc = 0;

    // Two reset edges with run held high.
    tick;
    load = 1'b0;
    tick;
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bank_sel", 32'(bank_sel), 32'd0);
    chk("reset_step_count", 32'(step_count), 32'd0);
    chk("reset_raddr", 32'(mem_raddr), 32'd0);
    chk("reset_waddr", 32'(mem_waddr), 32'd0);
    chk("reset_wu_u", wu_u, 32'd0);
    chk("reset_wu_du", wu_du, 32'd0);
    chk("reset_wu_uL", wu_uL, 32'd0);
    chk("reset_wu_uR", wu_uR, 32'd0);

    rst = 1'b0;
    tick;
    chk("post_reset_busy", 32'(busy), 32'd1);
    chk("post_reset_raddr", 32'(mem_raddr), 32'd0);

    // Two back-to-back steps, then a frame handoff with a long ready stall.
    run_step(-1, -1);
    run_step(-1, -1);
    do_tx(50, $urandom_range(1, 4));
    tick;

    // Run dropped mid-step: step and swap finish, then the block stays idle.
    run_step(3, -1);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_step_count", 32'(step_count), 32'(sc));
    end

    // Reset in the middle of a step, then restart from address 0.
    run = 1'b1;
    tick;
    run_step(-1, 5);
    tick;
    for (int k = 0; k < 6; k++) begin
      run_step(-1, -1);
      if (fc == 0) begin
        do_tx($urandom_range(0, 5), $urandom_range(1, 4));
        tick;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
